// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: registered one-hot grant plus binary index, held until
// release, owner withdrawal or hold-time limit, with a one-cycle idle gap on every handoff.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among req_i starting after last winner
//   GRANT | grant_o owned by grant_idx_o; watch rel, withdrawal, hold limit
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       rel_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_e           state_q;
  logic [1:0]       last_q;
  logic [1:0]       idx_q;
  logic [3:0]       grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       found;
  logic       owner_req;
  logic       at_limit;
  logic       end_any;

  // Scan upward from the slot after the last winner, wrapping 3 -> 0.
  always_comb begin
    win_idx = last_q;
    cand    = last_q;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req_i[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign owner_req = req_i[idx_q];
  assign at_limit  = (HOLD_MAX != 0) && (cnt_q == HOLD_LIM);
  assign end_any   = rel_i | ~owner_req | at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      grant_q   <= 4'b0000;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (|req_i) begin
            grant_q <= 4'b0001 << win_idx;
            idx_q   <= win_idx;
            cnt_q   <= CNT_W'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (end_any) begin
            grant_q   <= 4'b0000;
            last_q    <= idx_q;
            cnt_q     <= '0;
            // Only a pure timeout pulses; release or withdrawal takes precedence.
            timeout_q <= at_limit & ~rel_i & owner_req;
            state_q   <= IDLE;
          end else begin
            timeout_q <= 1'b0;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = |grant_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: two instances (HOLD_MAX=4 and HOLD_MAX=0) on shared inputs,
// checked against a per-owner behavioural model plus directed expectations.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;

  logic [3:0] grant_w [2];
  logic [1:0] idx_w   [2];
  logic       busy_w  [2];
  logic       to_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // model state per instance: owner -1 means idle
  int hold_of [2] = '{4, 0};
  int m_owner [2];
  int m_idx   [2];
  int m_last  [2];
  int m_held  [2];
  bit m_to    [2];

  always #5 clk = ~clk;

  rr_arbiter_4 #(.HOLD_MAX(4), .CNT_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .rel_i(rel),
    .grant_o(grant_w[0]), .grant_idx_o(idx_w[0]), .busy_o(busy_w[0]), .timeout_o(to_w[0]));

  rr_arbiter_4 #(.HOLD_MAX(0), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .rel_i(rel),
    .grant_o(grant_w[1]), .grant_idx_o(idx_w[1]), .busy_o(busy_w[1]), .timeout_o(to_w[1]));

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m_owner[h] = -1; m_idx[h] = 0; m_last[h] = 3; m_held[h] = 0; m_to[h] = 0;
    end
  endtask

  task automatic model_step();
    for (int h = 0; h < 2; h++) begin
      int c;
      bit wd, tmo;
      if (m_owner[h] < 0) begin
        m_to[h] = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last[h] + k) % 4;
          if (m_owner[h] < 0 && req[c]) begin
            m_owner[h] = c; m_idx[h] = c; m_held[h] = 1;
          end
        end
      end else begin
        wd  = !req[m_owner[h]];
        tmo = (hold_of[h] != 0) && (m_held[h] >= hold_of[h]);
        if (rel || wd || tmo) begin
          m_to[h] = tmo && !rel && !wd;
          m_last[h] = m_owner[h];
          m_owner[h] = -1;
        end else begin
          m_to[h] = 0;
          m_held[h]++;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(int h);
    return (m_owner[h] < 0) ? 4'b0000 : 4'(1 << m_owner[h]);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    for (int h = 0; h < 2; h++) begin
      n_checks++;
      if ({grant_w[h], idx_w[h], busy_w[h], to_w[h]} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got g=%b i=%0d b=%b t=%b, expected all zero",
                 h, grant_w[h], idx_w[h], busy_w[h], to_w[h]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 0000", grant_w[0]);
    end
  endtask

  task automatic test_rotation();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        for (int h = 0; h < 2; h++) begin
          n_checks++;
          if (grant_w[h] !== 4'(1 << (g % 4)) || idx_w[h] !== 2'(g % 4) || to_w[h] !== 1'b0
              || busy_w[h] !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation_grant dut%0d g%0d c%0d: got g=%b i=%0d b=%b t=%b, expected g=%b i=%0d b=1 t=0",
                     h, g, c, grant_w[h], idx_w[h], busy_w[h], to_w[h], 4'(1 << (g % 4)), g % 4);
          end
        end
      end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      for (int h = 0; h < 2; h++) begin
        n_checks++;
        if (grant_w[h] !== 4'b0000 || idx_w[h] !== 2'(g % 4) || busy_w[h] !== 1'b0 || to_w[h] !== 1'b0) begin
          n_fail++;
          $display("FAIL rotation_gap dut%0d g%0d: got g=%b i=%0d b=%b t=%b, expected g=0000 i=%0d b=0 t=0",
                   h, g, grant_w[h], idx_w[h], busy_w[h], to_w[h], g % 4);
        end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_single();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = 4'b0100;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0100 || idx_w[0] !== 2'd2) begin
      n_fail++; $display("FAIL single_grant: got g=%b i=%0d expected g=0100 i=2", grant_w[0], idx_w[0]);
    end
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    n_checks++;
    if (grant_w[0] !== 4'b0000 || busy_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got g=%b b=%b expected g=0000 b=0", grant_w[0], busy_w[0]);
    end
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0100) begin
      n_fail++; $display("FAIL single_regrant: got %b expected 0100", grant_w[0]);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0000 || to_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_withdraw: got g=%b t=%b expected g=0000 t=0", grant_w[0], to_w[0]);
    end
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (grant_w[0] !== 4'b0010 || to_w[0] !== 1'b0) begin
        n_fail++; $display("FAIL timeout_hold c%0d: got g=%b t=%b expected g=0010 t=0", c, grant_w[0], to_w[0]);
      end
    end
    req = 4'b1011;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0000 || to_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_pulse: got g=%b t=%b expected g=0000 t=1", grant_w[0], to_w[0]);
    end
    n_checks++;
    if (grant_w[1] !== 4'b0010 || to_w[1] !== 1'b0) begin
      n_fail++; $display("FAIL nolimit_hold: got g=%b t=%b expected g=0010 t=0", grant_w[1], to_w[1]);
    end
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b1000 || to_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_next_owner: got g=%b t=%b expected g=1000 t=0", grant_w[0], to_w[0]);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_end_at_limit();
    for (int mode = 0; mode < 2; mode++) begin
      req = 4'b0001;
      for (int c = 0; c < 4; c++) tick();
      if (mode == 0) rel = 1'b1; else req = 4'b0000;
      tick();
      rel = 1'b0; req = 4'b0000;
      n_checks++;
      if (grant_w[0] !== 4'b0000 || to_w[0] !== 1'b0) begin
        n_fail++; $display("FAIL limit_coincident m%0d: got g=%b t=%b expected g=0000 t=0", mode, grant_w[0], to_w[0]);
      end
      tick();
    end
  endtask

  task automatic test_withdraw();
    req = 4'b1000;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b1000 || idx_w[0] !== 2'd3) begin
      n_fail++; $display("FAIL withdraw_grant3: got g=%b i=%0d expected g=1000 i=3", grant_w[0], idx_w[0]);
    end
    tick();
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0000 || idx_w[0] !== 2'd3 || to_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_gap: got g=%b i=%0d t=%b expected g=0000 i=3 t=0", grant_w[0], idx_w[0], to_w[0]);
    end
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0001 || idx_w[0] !== 2'd0) begin
      n_fail++; $display("FAIL withdraw_next: got g=%b i=%0d expected g=0001 i=0", grant_w[0], idx_w[0]);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int h = 0; h < 2; h++) begin
      n_checks++;
      if (grant_w[h] !== 4'b0000 || busy_w[h] !== 1'b0 || to_w[h] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got g=%b b=%b t=%b expected all zero", h, grant_w[h], busy_w[h], to_w[h]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    tick();
    n_checks++;
    if (grant_w[0] !== 4'b0010 || idx_w[0] !== 2'd1) begin
      n_fail++; $display("FAIL reset_priority: got g=%b i=%0d expected g=0010 i=1", grant_w[0], idx_w[0]);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 7) == 0);
      tick();
      for (int h = 0; h < 2; h++) begin
        n_checks++;
        if (grant_w[h] !== exp_grant(h) || idx_w[h] !== 2'(m_idx[h]) || busy_w[h] !== (m_owner[h] >= 0)
            || to_w[h] !== m_to[h]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got g=%b i=%0d b=%b t=%b expected g=%b i=%0d b=%b t=%b",
                   h, n, grant_w[h], idx_w[h], busy_w[h], to_w[h], exp_grant(h), m_idx[h],
                   m_owner[h] >= 0, m_to[h]);
        end
      end
    end
    rel = 1'b0; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_end_at_limit();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
